// File: rtl/bram_arbiter_if.sv
// Requester-side and RAM-side signal bundle for bram_arbiter.
// slave = arbiter view, master = requesters plus RAM model view.
interface bram_arbiter_if #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 7
);
  logic                     p0_req;
  logic                     p0_we;
  logic                     p0_lock;
  logic [RAM_ADDR_BITS-1:0] p0_addr;
  logic [RAM_WIDTH-1:0]     p0_wdata;
  logic                     p0_gnt;
  logic                     p0_rvalid;
  logic [RAM_WIDTH-1:0]     p0_rdata;

  logic                     p1_req;
  logic                     p1_we;
  logic                     p1_lock;
  logic [RAM_ADDR_BITS-1:0] p1_addr;
  logic [RAM_WIDTH-1:0]     p1_wdata;
  logic                     p1_gnt;
  logic                     p1_rvalid;
  logic [RAM_WIDTH-1:0]     p1_rdata;

  logic                     ram_enable;
  logic                     write_enable;
  logic [RAM_ADDR_BITS-1:0] ram_address;
  logic [RAM_WIDTH-1:0]     ram_wdata;
  logic [RAM_WIDTH-1:0]     ram_rdata;

  modport slave (
    input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output ram_enable, write_enable, ram_address, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  ram_enable, write_enable, ram_address, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/bram_arbiter.sv
// Two-requester arbiter for one single-port BRAM with per-cycle grants and locked bursts.
// Define BRAM_ARB_FIXED_PRIO_EN to make port 0 win every idle-state tie (default: round robin).
module bram_arbiter #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 7
) (
  input  logic          clock,
  input  logic          reset_n,
  bram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state;
  logic   p0_rvalid_q;
  logic   p1_rvalid_q;
  logic   gnt0;
  logic   gnt1;
  logic   tie_to_p1;

`ifdef BRAM_ARB_FIXED_PRIO_EN
  assign tie_to_p1 = 1'b0;
`else
  logic last_gnt;

  // Tie goes to the port that did not win last; reset value 1 lets port 0 win first.
  assign tie_to_p1 = ~last_gnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt <= 1'b1;
    end else if (gnt0 || gnt1) begin
      last_gnt <= gnt1;
    end
  end
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      OWN0:    gnt0 = bus.p0_req;
      OWN1:    gnt1 = bus.p1_req;
      default: begin
        if (bus.p0_req && bus.p1_req) begin
          gnt0 = ~tie_to_p1;
          gnt1 = tie_to_p1;
        end else begin
          gnt0 = bus.p0_req;
          gnt1 = bus.p1_req;
        end
      end
    endcase
  end

  assign bus.p0_gnt       = gnt0;
  assign bus.p1_gnt       = gnt1;
  assign bus.ram_enable   = gnt0 | gnt1;
  assign bus.write_enable = (gnt0 & bus.p0_we) | (gnt1 & bus.p1_we);
  assign bus.ram_address  = gnt0 ? bus.p0_addr  : (gnt1 ? bus.p1_addr  : '0);
  assign bus.ram_wdata    = gnt0 ? bus.p0_wdata : (gnt1 ? bus.p1_wdata : '0);

  assign bus.p0_rvalid = p0_rvalid_q;
  assign bus.p1_rvalid = p1_rvalid_q;
  assign bus.p0_rdata  = bus.ram_rdata;
  assign bus.p1_rdata  = bus.ram_rdata;

  // Ownership FSM; the owner's lock is sampled every cycle, even while it is not requesting.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
    end else begin
      p0_rvalid_q <= gnt0 & ~bus.p0_we;
      p1_rvalid_q <= gnt1 & ~bus.p1_we;
      case (state)
        IDLE: begin
          if (gnt0 && bus.p0_lock) begin
            state <= OWN0;
          end else if (gnt1 && bus.p1_lock) begin
            state <= OWN1;
          end
        end
        OWN0: begin
          if (!bus.p0_lock) begin
            state <= IDLE;
          end
        end
        OWN1: begin
          if (!bus.p1_lock) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Randomized and directed bench for bram_arbiter with a behavioural reference model
// and a simple registered-output BRAM model attached to the RAM pins.
module tb_bram_arbiter;
  localparam int W = 32;
  localparam int A = 7;
`ifdef BRAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clock;
  logic reset_n;
  int   n_vec;
  int   n_err;

  bram_arbiter_if #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A)) bus ();

  bram_arbiter #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // BRAM stand-in: 1-cycle read latency, write-first on the same access.
  logic [W-1:0] fmem [0:(1<<A)-1];
  logic [W-1:0] ram_q;
  always @(posedge clock) begin
    if (bus.ram_enable) begin
      if (bus.write_enable) begin
        fmem[bus.ram_address] <= bus.ram_wdata;
        ram_q <= bus.ram_wdata;
      end else begin
        ram_q <= fmem[bus.ram_address];
      end
    end
  end
  assign bus.ram_rdata = ram_q;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: who owns the RAM, who won last, what data each port should see next.
  int           m_owner;
  bit           m_last;
  bit           m_pv0;
  bit           m_pv1;
  logic [W-1:0] m_pd;
  logic [W-1:0] ref_mem [0:(1<<A)-1];

  initial begin
    m_owner = -1;
    m_last  = 1'b1;
    m_pv0   = 1'b0;
    m_pv1   = 1'b0;
    m_pd    = '0;
  end

  always @(negedge clock) begin
    int           win;
    bit           e_we;
    logic [A-1:0] e_addr;
    logic [W-1:0] e_wd;
    if (!reset_n) begin
      m_owner = -1;
      m_last  = 1'b1;
      m_pv0   = 1'b0;
      m_pv1   = 1'b0;
    end
    win = -1;
    if (m_owner == 0) begin
      if (bus.p0_req) win = 0;
    end else if (m_owner == 1) begin
      if (bus.p1_req) win = 1;
    end else if (bus.p0_req && bus.p1_req) begin
      win = (FIXED || m_last) ? 0 : 1;
    end else if (bus.p0_req) begin
      win = 0;
    end else if (bus.p1_req) begin
      win = 1;
    end
    e_we   = (win == 0) ? bus.p0_we    : (win == 1) ? bus.p1_we    : 1'b0;
    e_addr = (win == 0) ? bus.p0_addr  : (win == 1) ? bus.p1_addr  : '0;
    e_wd   = (win == 0) ? bus.p0_wdata : (win == 1) ? bus.p1_wdata : '0;

    chk("p0_gnt", bus.p0_gnt, win == 0);
    chk("p1_gnt", bus.p1_gnt, win == 1);
    chk("ram_enable", bus.ram_enable, win >= 0);
    chk("write_enable", bus.write_enable, e_we);
    chk("ram_address", bus.ram_address, e_addr);
    chk("ram_wdata", bus.ram_wdata, e_wd);
    chk("p0_rvalid", bus.p0_rvalid, m_pv0);
    chk("p1_rvalid", bus.p1_rvalid, m_pv1);
    if (m_pv0) chk("p0_rdata", bus.p0_rdata, m_pd);
    if (m_pv1) chk("p1_rdata", bus.p1_rdata, m_pd);

    if (reset_n) begin
      m_pv0 = (win == 0) && !e_we;
      m_pv1 = (win == 1) && !e_we;
      if (win >= 0) begin
        if (e_we) ref_mem[e_addr] = e_wd;
        else      m_pd = ref_mem[e_addr];
        m_last = (win == 1);
      end
      if (m_owner == -1) begin
        if (win == 0 && bus.p0_lock)      m_owner = 0;
        else if (win == 1 && bus.p1_lock) m_owner = 1;
      end else if (m_owner == 0) begin
        if (!bus.p0_lock) m_owner = -1;
      end else begin
        if (!bus.p1_lock) m_owner = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic look();
    @(negedge clock);
  endtask

  task automatic idle_ports();
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_lock = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_lock = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
  endtask

  task automatic p0_write(input logic [A-1:0] a, input logic [W-1:0] d);
    bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_lock = 1'b0; bus.p0_addr = a; bus.p0_wdata = d;
    tick();
    bus.p0_req = 1'b0; bus.p0_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    bit g0;
    bit g1;
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    idle_ports();
    look();
    chk("reset p0_rvalid", bus.p0_rvalid, 1'b0);
    chk("reset p1_rvalid", bus.p1_rvalid, 1'b0);
    chk("reset ram_enable", bus.ram_enable, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;

    // Fill memory so the stand-in and the model agree on every address.
    for (int i = 0; i < (1 << A); i++) p0_write(i[A-1:0], $urandom);
    tick();

    // Write then cross-port read of the same word.
    bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 7'd5; bus.p0_wdata = 32'hDEAD_BEEF;
    look();
    chk("t1 p0_gnt", bus.p0_gnt, 1'b1);
    tick();
    bus.p0_req = 1'b0; bus.p0_we = 1'b0;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 7'd5;
    look();
    chk("t1 p1_gnt", bus.p1_gnt, 1'b1);
    chk("t1 p0_rvalid after write", bus.p0_rvalid, 1'b0);
    tick();
    bus.p1_req = 1'b0;
    look();
    chk("t1 p1_rvalid", bus.p1_rvalid, 1'b1);
    chk("t1 p1_rdata", bus.p1_rdata, 32'hDEAD_BEEF);
    chk("t1 p0_rvalid", bus.p0_rvalid, 1'b0);
    tick();

`ifndef BRAM_ARB_FIXED_PRIO_EN
    // Round robin; port 0 wrote last, so port 1 wins the first tie.
    p0_write(7'd1, 32'h1111_1111);
    p0_write(7'd2, 32'h2222_2222);
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 7'd1;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 7'd2;
    for (int k = 0; k < 6; k++) begin
      look();
      chk("t2 p1_gnt", bus.p1_gnt, (k % 2) == 0);
      chk("t2 p0_gnt", bus.p0_gnt, (k % 2) == 1);
      if (k > 0 && (k % 2) == 1) begin
        chk("t2 p1_rvalid", bus.p1_rvalid, 1'b1);
        chk("t2 p1_rdata", bus.p1_rdata, 32'h2222_2222);
      end else if (k > 0) begin
        chk("t2 p0_rvalid", bus.p0_rvalid, 1'b1);
        chk("t2 p0_rdata", bus.p0_rdata, 32'h1111_1111);
      end
      tick();
    end
    idle_ports();
    tick();
`endif

    // Port 1 locked burst stalls a waiting port 0.
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_lock = 1'b1; bus.p1_addr = 7'd3;
    look();
    chk("t3 p1_gnt first", bus.p1_gnt, 1'b1);
    tick();
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 7'd1;
    for (int k = 0; k < 3; k++) begin
      look();
      chk("t3 p0 stalled", bus.p0_gnt, 1'b0);
      chk("t3 p1_gnt", bus.p1_gnt, 1'b1);
      tick();
    end
    bus.p1_lock = 1'b0;
    look();
    chk("t3 p0 stalled unlock cycle", bus.p0_gnt, 1'b0);
    chk("t3 p1_gnt unlock cycle", bus.p1_gnt, 1'b1);
    tick();
    bus.p1_req = 1'b0;
    look();
    chk("t3 p0_gnt after release", bus.p0_gnt, 1'b1);
    tick();
    bus.p0_req = 1'b0;

    // Reset lands on the cycle a read result is due.
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 7'd7;
    look();
    chk("t4 p0_gnt", bus.p0_gnt, 1'b1);
    tick();
    bus.p0_req = 1'b0;
    reset_n = 1'b0;
    look();
    chk("t4 p0_rvalid dropped", bus.p0_rvalid, 1'b0);
    chk("t4 p1_rvalid dropped", bus.p1_rvalid, 1'b0);
    tick();
    reset_n = 1'b1;
    bus.p0_req = 1'b1; bus.p0_addr = 7'd1;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 7'd2;
    look();
    chk("t4 tie p0_gnt", bus.p0_gnt, 1'b1);
    chk("t4 tie p1_gnt", bus.p1_gnt, 1'b0);
    tick();
    idle_ports();
    tick();

    // Quiet period.
    for (int k = 0; k < 10; k++) begin
      look();
      chk("t5 ram_enable", bus.ram_enable, 1'b0);
      chk("t5 write_enable", bus.write_enable, 1'b0);
      chk("t5 p0_rvalid", bus.p0_rvalid, 1'b0);
      chk("t5 p1_rvalid", bus.p1_rvalid, 1'b0);
      tick();
    end

`ifdef BRAM_ARB_FIXED_PRIO_EN
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 7'd1;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 7'd2;
    for (int k = 0; k < 8; k++) begin
      look();
      chk("t6 p0_gnt", bus.p0_gnt, 1'b1);
      chk("t6 p1_gnt", bus.p1_gnt, 1'b0);
      tick();
    end
    idle_ports();
    tick();
`endif

    // Random traffic; a requester holds its request fields until granted.
    for (int i = 0; i < 600; i++) begin
      look();
      g0 = bus.p0_gnt;
      g1 = bus.p1_gnt;
      tick();
      if (!(bus.p0_req && !g0)) begin
        bus.p0_req   = ($urandom % 4) != 0;
        bus.p0_we    = $urandom % 2;
        bus.p0_addr  = A'($urandom);
        bus.p0_wdata = $urandom;
      end
      if (!(bus.p1_req && !g1)) begin
        bus.p1_req   = ($urandom % 4) != 0;
        bus.p1_we    = ($urandom % 4) == 0;
        bus.p1_addr  = A'($urandom);
        bus.p1_wdata = $urandom;
      end
      if (($urandom % 6) == 0) bus.p0_lock = ~bus.p0_lock;
      if (($urandom % 6) == 0) bus.p1_lock = ~bus.p1_lock;
    end
    idle_ports();
    tick();
    tick();
    look();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
